// File: rtl/seg_scan_ctrl.sv
// Scan controller for a common-select, active-low 7-segment display with
// frame-aligned data swap, inter-digit blanking and leading-zero suppression.
module seg_scan_ctrl #(
   parameter int unsigned DIGITS    = 6,
   parameter int unsigned DWELL_CYC = 50000,
   parameter int unsigned BLANK_CYC = 500
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [4*DIGITS-1:0]   load_data,
   input  logic                  lz_blank,
   output logic [6:0]            segment,
   output logic [DIGITS-1:0]     seg_sel,
   output logic                  frame_done
);

   localparam int unsigned DATA_W  = 4 * DIGITS;
   localparam int unsigned CNT_MAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned DIG_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic {
      S_BLANK = 1'b0,
      S_DRIVE = 1'b1
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [DIG_W-1:0]    digit;
   logic [DATA_W-1:0]   shadow;
   logic [DATA_W-1:0]   pending;

   logic [DIGITS-1:0]   lz_mask;
   logic [3:0]          cur_nib;
   logic [6:0]          seg_next_c;
   logic                last_digit_c;
   logic                boundary_c;

   // Active-high segment pattern for a BCD nibble; non-BCD codes stay dark.
   function automatic logic [6:0] enc(input logic [3:0] n);
      case (n)
         4'd0:    enc = 7'h77;
         4'd1:    enc = 7'h24;
         4'd2:    enc = 7'h5D;
         4'd3:    enc = 7'h6D;
         4'd4:    enc = 7'h2E;
         4'd5:    enc = 7'h6B;
         4'd6:    enc = 7'h7B;
         4'd7:    enc = 7'h25;
         4'd8:    enc = 7'h7F;
         4'd9:    enc = 7'h6F;
         default: enc = 7'h00;
      endcase
   endfunction

   // A digit is a leading zero when it and every more-significant digit are zero.
   always_comb begin
      logic zero_above;
      lz_mask    = '0;
      zero_above = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         zero_above = zero_above & (shadow[4*k +: 4] == 4'd0);
         lz_mask[k] = zero_above;
      end
   end

   always_comb begin
      cur_nib      = shadow[4*int'(digit) +: 4];
      seg_next_c   = (lz_blank && lz_mask[digit]) ? 7'h7F : ~enc(cur_nib);
      last_digit_c = (digit == DIG_W'(DIGITS - 1));
      boundary_c   = (state == S_DRIVE) && (cnt == '0) && last_digit_c;
   end

   // Scan sequencer, display registers and one-entry load buffer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_BLANK;
         cnt        <= CNT_W'(BLANK_CYC - 1);
         digit      <= '0;
         shadow     <= '0;
         pending    <= '0;
         load_ready <= 1'b1;
         segment    <= 7'h7F;
         seg_sel    <= '1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            S_BLANK: begin
               if (cnt == '0) begin
                  state   <= S_DRIVE;
                  cnt     <= CNT_W'(DWELL_CYC - 1);
                  seg_sel <= ~(DIGITS'(1) << digit);
                  segment <= seg_next_c;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_DRIVE: begin
               segment <= seg_next_c;
               if (cnt == '0) begin
                  state   <= S_BLANK;
                  cnt     <= CNT_W'(BLANK_CYC - 1);
                  seg_sel <= '1;
                  segment <= 7'h7F;
                  if (last_digit_c) begin
                     digit      <= '0;
                     frame_done <= 1'b1;
                  end else begin
                     digit <= digit + DIG_W'(1);
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state   <= S_BLANK;
               cnt     <= CNT_W'(BLANK_CYC - 1);
               seg_sel <= '1;
               segment <= 7'h7F;
            end
         endcase

         // Accept and frame-boundary transfer are exclusive: accept needs an empty slot.
         if (load_valid && load_ready) begin
            pending    <= load_data;
            load_ready <= 1'b0;
         end else if (boundary_c && !load_ready) begin
            shadow     <= pending;
            load_ready <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized scoreboard bench for seg_scan_ctrl (6 digits, dwell 4, blank 1).
module tb_seg_scan_ctrl;

   localparam int unsigned DIGITS = 6;
   localparam int unsigned DWELL  = 4;
   localparam int unsigned BLANK  = 1;
   localparam int unsigned SLOT   = DWELL + BLANK;
   localparam int unsigned FRAME  = DIGITS * SLOT;

   localparam logic [6:0] ENC [10] = '{7'h77, 7'h24, 7'h5D, 7'h6D, 7'h2E,
                                       7'h6B, 7'h7B, 7'h25, 7'h7F, 7'h6F};

   logic        clk = 1'b0;
   logic        rst;
   logic        load_valid;
   logic        load_ready;
   logic [23:0] load_data;
   logic        lz_blank;
   logic [6:0]  segment;
   logic [5:0]  seg_sel;
   logic        frame_done;

   typedef struct {
      logic [23:0] data;
      int          stamp;
   } load_t;

   load_t       pend_q[$];
   logic [23:0] shadow_m;
   int          edge_cnt;
   bit          last_lz;
   int          n_cmp = 0;
   int          n_err = 0;

   seg_scan_ctrl #(.DIGITS(DIGITS), .DWELL_CYC(DWELL), .BLANK_CYC(BLANK)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .lz_blank   (lz_blank),
      .segment    (segment),
      .seg_sel    (seg_sel),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] exp_seg(input logic [23:0] v, input int d, input bit lz);
      int n;
      n = int'((v >> (4 * d)) & 24'hF);
      if (lz && d > 0 && (v >> (4 * d)) == 24'h0) return 7'h7F;
      if (n > 9) return 7'h7F;
      return ~ENC[n];
   endfunction

   // Edges since reset release, and lz_blank as seen at the latest edge.
   always @(posedge clk) begin
      if (!rst) edge_cnt = 0;
      else edge_cnt++;
      last_lz = lz_blank;
   end

   // Monitor: position in the frame follows from the edge count alone.
   always @(negedge clk) begin
      if (!rst) begin
         shadow_m = 24'h0;
         pend_q.delete();
      end else begin
         int e, q, d, npend;
         bit drive;
         logic [5:0] sel_e;
         logic [6:0] seg_e;
         e = edge_cnt;
         if (e > 0 && e % FRAME == 0 && pend_q.size() > 0 && pend_q[0].stamp < e) begin
            shadow_m = pend_q[0].data;
            void'(pend_q.pop_front());
         end
         npend = 0;
         foreach (pend_q[i]) if (pend_q[i].stamp <= e) npend++;
         q     = e % FRAME;
         d     = q / SLOT;
         drive = (q % SLOT) != 0;
         sel_e = drive ? ~(6'd1 << d) : 6'h3F;
         seg_e = drive ? exp_seg(shadow_m, d, last_lz) : 7'h7F;
         check("seg_sel", 32'(seg_sel), 32'(sel_e));
         check("segment", 32'(segment), 32'(seg_e));
         check("frame_done", 32'(frame_done), 32'(e > 0 && q == 0));
         check("load_ready", 32'(load_ready), 32'(npend == 0));
      end
   end

   task automatic load(input logic [23:0] d);
      bit done = 0;
      @(negedge clk);
      load_valid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         if (i > 0) @(negedge clk);
         if (load_ready) begin
            load_data = d;
            pend_q.push_back('{data: d, stamp: edge_cnt + 1});
            done = 1;
         end else begin
            load_data = 24'($urandom);
         end
      end
      if (!done) begin
         n_cmp++; n_err++;
         $display("FAIL load_timeout: ready stayed %0b expected 1", load_ready);
      end
      @(posedge clk);
      #1 load_valid = 1'b0;
   endtask

   // Handshake lands exactly on the frame-boundary edge.
   task automatic load_at_boundary(input logic [23:0] d);
      bit done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (edge_cnt % FRAME == FRAME - 1 && load_ready) begin
            load_valid = 1'b1;
            load_data  = d;
            pend_q.push_back('{data: d, stamp: edge_cnt + 1});
            done = 1;
         end
      end
      if (!done) begin
         n_cmp++; n_err++;
         $display("FAIL boundary_timeout: ready %0b expected 1", load_ready);
      end
      @(posedge clk);
      #1 load_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst        = 1'b0;
      load_valid = 1'b0;
      load_data  = 24'h0;
      lz_blank   = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("rst_segment", 32'(segment), 32'h7F);
      check("rst_seg_sel", 32'(seg_sel), 32'h3F);
      check("rst_ready", 32'(load_ready), 32'h1);
      check("rst_frame_done", 32'(frame_done), 32'h0);
      @(posedge clk);
      #2 rst = 1'b1;

      idle(2 * FRAME);

      load(24'h123456);
      idle(2 * FRAME);

      @(negedge clk) lz_blank = 1'b1;
      load(24'h000070);
      idle(2 * FRAME);

      @(negedge clk) lz_blank = 1'b0;
      load(24'h111111);
      load(24'h222222);
      idle(3 * FRAME);
      load_at_boundary(24'h345678);
      idle(3 * FRAME);

      // Asynchronous reset in the middle of digit 3's dwell.
      @(negedge clk) lz_blank = 1'b1;
      begin
         bit hit = 0;
         for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (edge_cnt % FRAME == 3 * SLOT + 2) hit = 1;
         end
         if (!hit) begin
            n_cmp++; n_err++;
            $display("FAIL digit3_wait: edge %0d expected phase %0d", edge_cnt, 3 * SLOT + 2);
         end
      end
      #1 rst = 1'b0;
      #1;
      check("arst_segment", 32'(segment), 32'h7F);
      check("arst_seg_sel", 32'(seg_sel), 32'h3F);
      check("arst_frame_done", 32'(frame_done), 32'h0);
      check("arst_ready", 32'(load_ready), 32'h1);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      idle(FRAME + 3);

      for (int it = 0; it < 25; it++) begin
         logic [23:0] v;
         v = 24'($urandom);
         if ($urandom_range(0, 1) == 1) v = v >> (4 * $urandom_range(0, 6));
         @(negedge clk) lz_blank = 1'($urandom_range(0, 1));
         load(v);
         idle($urandom_range(0, 40));
      end
      idle(3 * FRAME);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time %0t expected completion earlier", $time);
      $fatal(1);
   end

endmodule
